// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: pin synchronisation, clock glitch filter, 11-bit frame deframing
// with parity/stop/timeout checks, and a small byte FIFO read by the CPU bus decoder.
module ps2_key_fifo #(
  parameter int FIFO_AW  = 3,
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ps2_rd,
  output logic [7:0] key,
  output logic       ps2_ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  logic [1:0]          clk_sync_reg, data_sync_reg;
  logic [FILT_LEN-1:0] hist_reg;
  logic                filt_reg;
  logic                smp, data_bit;

  state_t              state_reg, state_next;
  logic [2:0]          bitcnt_reg, bitcnt_next;
  logic [7:0]          byte_reg, byte_next;
  logic                par_reg, par_next;
  logic                push_reg, push_next;
  logic                ferr_set;
  logic [TW-1:0]       tcnt_reg, tcnt_next;

  logic [FIFO_AW:0]    wr_ptr_reg, rd_ptr_reg;
  logic                rd_q_reg, overflow_reg, frame_err_reg;
  logic [7:0]          mem [DEPTH];
  logic                empty, full, pop, do_write;

  // Filtered clock only changes once the whole sample history agrees.
  assign smp      = filt_reg & ~(|hist_reg);
  assign data_bit = data_sync_reg[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      hist_reg      <= '1;
      filt_reg      <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      hist_reg      <= {hist_reg[FILT_LEN-2:0], clk_sync_reg[1]};
      if (&hist_reg)
        filt_reg <= 1'b1;
      else if (~(|hist_reg))
        filt_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bitcnt_next = bitcnt_reg;
    byte_next   = byte_reg;
    par_next    = par_reg;
    push_next   = 1'b0;
    ferr_set    = 1'b0;
    tcnt_next   = (state_reg == IDLE || smp) ? '0 : tcnt_reg + TW'(1);
    if (smp) begin
      case (state_reg)
        IDLE: if (!data_bit) begin
          state_next  = DATA;
          bitcnt_next = 3'd0;
        end
        DATA: begin
          byte_next = {data_bit, byte_reg[7:1]};
          if (bitcnt_reg == 3'd7)
            state_next = PAR;
          else
            bitcnt_next = bitcnt_reg + 3'd1;
        end
        PAR: begin
          par_next   = data_bit;
          state_next = STOP;
        end
        default: begin
          if (data_bit && (^{byte_reg, par_reg}))
            push_next = 1'b1;
          else
            ferr_set = 1'b1;
          state_next = IDLE;
        end
      endcase
    end else if (state_reg != IDLE && tcnt_reg == TW'(TIMEOUT - 1)) begin
      state_next = IDLE;
      ferr_set   = 1'b1;
      tcnt_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      bitcnt_reg <= 3'd0;
      byte_reg   <= 8'h00;
      par_reg    <= 1'b0;
      push_reg   <= 1'b0;
      tcnt_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      bitcnt_reg <= bitcnt_next;
      byte_reg   <= byte_next;
      par_reg    <= par_next;
      push_reg   <= push_next;
      tcnt_reg   <= tcnt_next;
    end
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                 (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
  // One pop per strobe rising edge; a pop frees the slot for a same-cycle push.
  assign pop       = ps2_rd & ~rd_q_reg & ~empty;
  assign do_write  = push_reg & (~full | pop);
  assign ps2_ready = ~empty;
  assign key       = empty ? 8'h00 : mem[rd_ptr_reg[FIFO_AW-1:0]];
  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      rd_q_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rd_q_reg <= ps2_rd;
      if (do_write)
        wr_ptr_reg <= wr_ptr_reg + (FIFO_AW+1)'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + (FIFO_AW+1)'(1);
      if (push_reg && full && !pop)
        overflow_reg <= 1'b1;
      if (ferr_set)
        frame_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write)
      mem[wr_ptr_reg[FIFO_AW-1:0]] <= byte_reg;
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Randomised bench for ps2_key_fifo: drives PS/2 frames on the pins and compares the
// CPU-side outputs with a queue-based model of the keyboard FIFO.
module tb_ps2_key_fifo;

  localparam int AW    = 3;
  localparam int FL    = 4;
  localparam int TO    = 2000;
  localparam int HALF  = 16;
  localparam int DEPTH = 1 << AW;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ps2_rd = 1'b0;
  logic [7:0] key;
  logic       ps2_ready, overflow, frame_err;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_ferr = 1'b0;

  always #5 clk = ~clk;

  ps2_key_fifo #(.FIFO_AW(AW), .FILT_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_rd(ps2_rd),
    .key(key), .ps2_ready(ps2_ready), .overflow(overflow), .frame_err(frame_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_state(input string ctx);
    logic [7:0] exp_key;
    exp_key = (q.size() != 0) ? q[0] : 8'h00;
    check_val({ctx, " key"}, 32'(key), 32'(exp_key));
    check_val({ctx, " ready"}, 32'(ps2_ready), 32'(q.size() != 0));
    check_val({ctx, " overflow"}, 32'(overflow), 32'(m_ovf));
    check_val({ctx, " frame_err"}, 32'(frame_err), 32'(m_ferr));
    $display("%s: key=%02h ready=%0b ovf=%0b ferr=%0b depth=%0d",
             ctx, key, ps2_ready, overflow, frame_err, q.size());
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    @(negedge clk);
    ps2_data = b;
    if (glitch) begin
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat ($urandom_range(1, FL - 1)) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic par;
    par = (~(^b)) ^ bad_par;
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(par, glitch);
    ps2_bit(~bad_stop, glitch);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    if (bad_par || bad_stop) m_ferr = 1'b1;
    else if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic read_pulse(input int hold);
    @(negedge clk);
    ps2_rd = 1'b1;
    repeat (hold) @(negedge clk);
    ps2_rd = 1'b0;
    @(negedge clk);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic idle_glitch();
    @(negedge clk);
    ps2_clk = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    int op;
    repeat (3) @(negedge clk);
    check_val("reset key", 32'(key), 32'h0);
    check_val("reset ready", 32'(ps2_ready), 32'h0);
    check_val("reset overflow", 32'(overflow), 32'h0);
    check_val("reset frame_err", 32'(frame_err), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'h1C, 0, 0, 0);  check_state("t1 frame 1C");
    read_pulse(1);               check_state("t1 after read");

    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);  check_state("t2 F0,1C");
    read_pulse(10);              check_state("t2 held read");
    read_pulse(1);               check_state("t2 reraise");

    send_frame(8'h1C, 1, 0, 0);  check_state("t3 bad parity");
    send_frame(8'h32, 0, 0, 0);  check_state("t3 good 32");
    read_pulse(2);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
    check_state("t4 nine frames");
    for (int i = 0; i < 8; i++) begin
      read_pulse(1);
      check_state($sformatf("t4 pop %0d", i));
    end

    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
    repeat (TO + 100) @(negedge clk);
    m_ferr = 1'b1;               check_state("t5 timeout");
    send_frame(8'h5A, 0, 0, 0);  check_state("t5 frame 5A");
    read_pulse(1);

    idle_glitch();
    idle_glitch();               check_state("t6 idle glitch");
    send_frame(8'hA7, 0, 0, 1);  check_state("t6 glitched frame");
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("rst key", 32'(key), 32'h0);
    check_val("rst ready", 32'(ps2_ready), 32'h0);
    check_val("rst overflow", 32'(overflow), 32'h0);
    check_val("rst frame_err", 32'(frame_err), 32'h0);
    q.delete();
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h3B, 0, 0, 0);  check_state("t6 after reset");

    for (int n = 0; n < 30; n++) begin
      op = int'($urandom_range(0, 6));
      case (op)
        0, 1, 2: send_frame(8'($urandom_range(0, 255)), 0, 0, bit'($urandom_range(0, 1)));
        3:       send_frame(8'($urandom_range(0, 255)), 1, 0, 0);
        4:       send_frame(8'($urandom_range(0, 255)), 0, 1, 0);
        default: read_pulse(int'($urandom_range(1, 6)));
      endcase
      check_state($sformatf("rand %0d op %0d", n, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
